wb_commit_ctrl: RTL and testbench

- Writeback controller: the initiator side of the register-file write port.
- Merges ALU/immediate results from execute with in-order load data returning from data memory onto the single write port (regwrite / write_register / write_data).
- Tracks outstanding loads in a small in-order queue and exports per-register busy flags so decode can stall on load-use hazards.

---
 rtl/wb_commit_ctrl_pkg.sv | 19 +
 rtl/wb_load_queue.sv | 64 ++++++
 rtl/wb_commit_ctrl.sv | 146 ++++++++++++++
 tb/tb_wb_commit_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_ctrl_pkg.sv
// Shared widths, constants and load funct3 encodings for the writeback controller.
package wb_commit_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic                  WRITE_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/wb_load_queue.sv
// In-order FIFO of outstanding load destinations with a per-entry rd match
// vector so decode can detect load-use hazards against every live entry.
module wb_load_queue #(
  parameter int ENTRY_W = 5,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [ENTRY_W-1:0]         push_entry_i,
  input  logic                       pop_i,
  output logic [ENTRY_W-1:0]         head_entry_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  input  logic [ADDR_W-1:0]          rs1_addr_i,
  input  logic [ADDR_W-1:0]          rs2_addr_i,
  output logic [DEPTH-1:0]           rs1_hit_o,
  output logic [DEPTH-1:0]           rs2_hit_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     offset;
  logic                 live;

  // The extra wrap bit makes pointer difference the exact occupancy.
  assign count_o      = wr_ptr_q - rd_ptr_q;
  assign full_o       = (count_o == (PTR_W+1)'(DEPTH));
  assign empty_o      = (count_o == '0);
  assign head_entry_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; liveness comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_i;
  end

  always_comb begin
    offset    = '0;
    live      = 1'b0;
    rs1_hit_o = '0;
    rs2_hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
      live         = ({1'b0, offset} < count_o);
      rs1_hit_o[i] = live && (mem_q[i][ADDR_W-1:0] == rs1_addr_i);
      rs2_hit_o[i] = live && (mem_q[i][ADDR_W-1:0] == rs2_addr_i);
    end
  end

endmodule

// File: rtl/wb_commit_ctrl.sv
// Writeback controller: merges execute results and in-order load returns onto
// the register-file write port. `WB_LOAD_EXT_EN enables load byte/half extension.
module wb_commit_ctrl
  import wb_commit_ctrl_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_we,
  input  logic                      ex_is_load,
  input  logic [ADDR_W-1:0]         ex_rd,
  input  logic [DATA_W-1:0]         ex_data,
  input  logic [4:0]                ex_ld_ctl,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      regwrite,
  output logic [ADDR_W-1:0]         write_register,
  output logic [DATA_W-1:0]         write_data,
  output logic [$clog2(LQ_DEPTH):0] lq_count,
  output logic                      lq_err
);

`ifdef WB_LOAD_EXT_EN
  localparam int ENTRY_W = ADDR_W + 5;
`else
  localparam int ENTRY_W = ADDR_W;
`endif

  logic                accept, push, pop, full, empty;
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic [ADDR_W-1:0]   head_rd;
  logic [DATA_W-1:0]   load_data;
  logic [LQ_DEPTH-1:0] rs1_hit, rs2_hit;

  logic                regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]   write_register_q, write_register_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                lq_err_q, lq_err_d;

  // A same-cycle pop frees a slot, so a full queue can still take a load.
  always_comb begin
    if (ex_is_load)  ex_ready = !full || mem_rvalid;
    else if (ex_we)  ex_ready = !mem_rvalid;
    else             ex_ready = 1'b1;
  end

  assign accept  = ex_valid && ex_ready;
  assign push    = accept && ex_is_load;
  assign pop     = mem_rvalid && !empty;
  assign head_rd = head_entry[ADDR_W-1:0];

`ifdef WB_LOAD_EXT_EN
  logic [4:0]        head_ctl;
  logic [DATA_W-1:0] shifted;

  assign push_entry = {ex_ld_ctl, ex_rd};
  assign head_ctl   = head_entry[ENTRY_W-1:ADDR_W];

  always_comb begin
    shifted = mem_rdata >> {head_ctl[1:0], 3'b000};
    case (head_ctl[4:2])
      LD_LB:   load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LD_LH:   load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LD_LW:   load_data = shifted;
      LD_LBU:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LD_LHU:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end
`else
  logic unused_ld_ctl;

  assign push_entry    = ex_rd;
  assign load_data     = mem_rdata;
  assign unused_ld_ctl = ^ex_ld_ctl;
`endif

  wb_load_queue #(
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (LQ_DEPTH)
  ) u_lq (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_entry_o (head_entry),
    .count_o      (lq_count),
    .full_o       (full),
    .empty_o      (empty),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rs1_hit_o    (rs1_hit),
    .rs2_hit_o    (rs2_hit)
  );

  assign rs1_busy = (rs1_addr != '0) && (|rs1_hit);
  assign rs2_busy = (rs2_addr != '0) && (|rs2_hit);

  // Load returns own the port; execute writes are already held off by ex_ready.
  always_comb begin
    regwrite_d       = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    lq_err_d         = lq_err_q || (mem_rvalid && empty);
    if (pop) begin
      regwrite_d       = (head_rd != '0);
      write_register_d = head_rd;
      write_data_d     = load_data;
    end else if (accept && !ex_is_load && ex_we && ex_rd != '0) begin
      regwrite_d       = WRITE_ENABLE;
      write_register_d = ex_rd;
      write_data_d     = ex_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q       <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      lq_err_q         <= 1'b0;
    end else begin
      regwrite_q       <= regwrite_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      lq_err_q         <= lq_err_d;
    end
  end

  assign regwrite       = regwrite_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign lq_err         = lq_err_q;

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Directed bench for wb_commit_ctrl with a write scoreboard and a load-queue model.
module tb_wb_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic [4:0]  ex_ld_ctl;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        regwrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [2:0]  lq_count;
  logic        lq_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [36:0] exp_q [$];
  logic [4:0]  model_lq [$];

  always #5 clk = ~clk;

  wb_commit_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_we          (ex_we),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_data        (ex_data),
    .ex_ld_ctl      (ex_ld_ctl),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .regwrite       (regwrite),
    .write_register (write_register),
    .write_data     (write_data),
    .lq_count       (lq_count),
    .lq_err         (lq_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge and matched against the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, write_register}, 64'h1f);
      end else begin
        e = exp_q.pop_front();
        check("sb_reg", {59'd0, write_register}, {59'd0, e[36:32]});
        check("sb_data", {32'd0, write_data}, {32'd0, e[31:0]});
      end
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
    ex_ld_ctl = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [4:0] ctl);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = rd; ex_ld_ctl = ctl;
    model_lq.push_back(rd);
  endtask

  // Drive a memory response and schedule the write it should cause.
  task automatic respond(input logic [31:0] data, input logic [31:0] exp_data);
    logic [4:0] rd;
    mem_rvalid = 1; mem_rdata = data;
    rd = model_lq.pop_front();
    if (rd != 0) exp_q.push_back({rd, exp_data});
  endtask

  initial begin
    idle();
    rs1_addr = 0; rs2_addr = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_regwrite", {63'd0, regwrite}, 64'd0);
    check("rst_wreg", {59'd0, write_register}, 64'd0);
    check("rst_wdata", {32'd0, write_data}, 64'd0);
    check("rst_count", {61'd0, lq_count}, 64'd0);
    check("rst_err", {63'd0, lq_err}, 64'd0);

    // ALU write, then rd=x0 which must not write and must hold address/data
    ex_valid = 1; ex_we = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    #1 check("alu_ready", {63'd0, ex_ready}, 64'd1);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    check("alu_regwrite", {63'd0, regwrite}, 64'd1);
    ex_rd = 0; ex_data = 32'h1;
    tick();
    check("x0_no_write", {63'd0, regwrite}, 64'd0);
    check("x0_hold_reg", {59'd0, write_register}, 64'd5);
    check("x0_hold_data", {32'd0, write_data}, 64'hDEADBEEF);
    idle();

    // Load-use: busy while pending, including the pop cycle
    issue_load(5'd7, 5'b010_00);
    tick();
    idle();
    rs1_addr = 7; rs2_addr = 0;
    #1;
    check("lu_busy1", {63'd0, rs1_busy}, 64'd1);
    check("lu_busy2_x0", {63'd0, rs2_busy}, 64'd0);
    check("lu_count", {61'd0, lq_count}, 64'd1);
    respond(32'h12345678, 32'h12345678);
    #1 check("lu_busy_pop", {63'd0, rs1_busy}, 64'd1);
    tick();
    idle();
    #1;
    check("lu_busy_clr", {63'd0, rs1_busy}, 64'd0);
    check("lu_count0", {61'd0, lq_count}, 64'd0);

    // Collision: memory response owns the port, ALU write waits a cycle
    issue_load(5'd9, 5'b010_00);
    tick();
    idle();
    ex_valid = 1; ex_we = 1; ex_rd = 3; ex_data = 32'hAAAA5555;
    respond(32'h00000011, 32'h00000011);
    #1 check("col_stall", {63'd0, ex_ready}, 64'd0);
    tick();
    check("col_load_first", {59'd0, write_register}, 64'd9);
    mem_rvalid = 0;
    #1 check("col_ready", {63'd0, ex_ready}, 64'd1);
    exp_q.push_back({5'd3, 32'hAAAA5555});
    tick();
    check("col_alu_after", {59'd0, write_register}, 64'd3);
    idle();

    // Full queue, push+pop at full, wrap-around with an x0 load mixed in
    for (int i = 0; i < 4; i++) begin
      issue_load(5'(10 + i), 5'b010_00);
      tick();
    end
    idle();
    #1 check("full_count", {61'd0, lq_count}, 64'd4);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 14; ex_ld_ctl = 5'b010_00;
    #1 check("full_stall", {63'd0, ex_ready}, 64'd0);
    respond(32'h100, 32'h100);
    #1 check("full_pushpop_ready", {63'd0, ex_ready}, 64'd1);
    model_lq.push_back(5'd14);
    tick();
    check("full_count_hold", {61'd0, lq_count}, 64'd4);
    for (int i = 0; i < 6; i++) begin
      issue_load((i == 2) ? 5'd0 : 5'(15 + i), 5'b010_00);
      respond(32'h200 + 32'(i), 32'h200 + 32'(i));
      tick();
    end
    ex_valid = 0;
    for (int i = 0; i < 4; i++) begin
      respond(32'h300 + 32'(i), 32'h300 + 32'(i));
      tick();
    end
    idle();
    #1 check("drain_count", {61'd0, lq_count}, 64'd0);

    // Spurious response: sticky error, no write
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    tick();
    idle();
    check("spur_err", {63'd0, lq_err}, 64'd1);
    check("spur_no_write", {63'd0, regwrite}, 64'd0);
    tick();
    check("spur_sticky", {63'd0, lq_err}, 64'd1);

    // Reset dominates: pending load discarded, error cleared
    issue_load(5'd8, 5'b010_00);
    tick();
    idle();
    void'(model_lq.pop_front());
    rst = 1;
    mem_rvalid = 1; mem_rdata = 32'h55;
    tick();
    rst = 0;
    idle();
    #1;
    check("rst2_count", {61'd0, lq_count}, 64'd0);
    check("rst2_err", {63'd0, lq_err}, 64'd0);
    check("rst2_regwrite", {63'd0, regwrite}, 64'd0);

    // Byte/half extension (raw word when the feature is compiled out)
    issue_load(5'd4, 5'b000_10);
    tick();
    idle();
`ifdef WB_LOAD_EXT_EN
    respond(32'h00800000, 32'hFFFFFF80);
`else
    respond(32'h00800000, 32'h00800000);
`endif
    tick();
    idle();
    issue_load(5'd6, 5'b101_10);
    tick();
    idle();
`ifdef WB_LOAD_EXT_EN
    respond(32'hFFFF0000, 32'h0000FFFF);
`else
    respond(32'hFFFF0000, 32'hFFFF0000);
`endif
    tick();
    idle();
    tick();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("model_lq_drained", 64'(model_lq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
